// File: rtl/col_parity_apply.sv
// col_parity_apply: mixes each slice with the column parities of its own and previous slice, writing the result back in place.
module col_parity_apply #(
  parameter int N_SLICE = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [24:0]       mem_line,
  input  logic [24:0]       par_line,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [24:0]       write_value,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, PRELOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [4:0] prev_par, prev_n, c, d;
  logic last, unused_par;
  assign c = par_line[4:0];
  assign unused_par = ^par_line[24:5];
  assign last = rd_addr == ADDR_W'(N_SLICE - 1);
  for (genvar x = 0; x < 5; x++) begin : g_d
    assign d[x] = c[(x + 4) % 5] ^ prev_par[(x + 1) % 5];
  end
  assign wr_en = state == RUN;
  assign busy = state == PRELOAD || state == RUN;
  assign done = state == DONE;
  assign write_value = wr_en ? mem_line ^ {5{d}} : 25'h0;
  always_comb begin
    state_n = state;
    addr_n = rd_addr;
    prev_n = prev_par;
    case (state)
      IDLE: begin
        addr_n = start ? ADDR_W'(N_SLICE - 1) : '0;
        state_n = start ? PRELOAD : IDLE;
      end
      PRELOAD: begin
        prev_n = c;
        addr_n = '0;
        state_n = RUN;
      end
      RUN: begin
        prev_n = c;
        addr_n = last ? '0 : rd_addr + 1'b1;
        state_n = last ? DONE : RUN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_addr <= '0;
      prev_par <= '0;
    end else begin
      state <= state_n;
      rd_addr <= addr_n;
      prev_par <= prev_n;
    end
endmodule

// File: tb/tb_col_parity_apply.sv
// tb_col_parity_apply: directed table-driven bench for col_parity_apply against a combinational memory model.
module tb_col_parity_apply;
  logic clk = 0, rst = 1, start = 0, clr = 0;
  logic [24:0] mem_line, par_line, write_value;
  logic [5:0] rd_addr;
  logic wr_en, busy, done;
  logic [24:0] mem [64];
  logic [24:0] par [64];
  logic [24:0] wr [64];
  logic wr_hit [64];
  int wr_cnt, done_cnt, n_chk = 0, n_fail = 0;
  typedef struct {int scen; int z; logic [24:0] exp;} vec_t;
  vec_t vt[14];
  col_parity_apply dut (
    .clk(clk), .rst(rst), .start(start), .mem_line(mem_line), .par_line(par_line),
    .rd_addr(rd_addr), .wr_en(wr_en), .write_value(write_value), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign mem_line = mem[rd_addr];
  assign par_line = par[rd_addr];
  always @(posedge clk)
    if (clr) begin
      wr_cnt <= 0;
      done_cnt <= 0;
      for (int i = 0; i < 64; i++) wr_hit[i] <= 0;
    end else begin
      if (wr_en) begin
        wr[rd_addr] <= write_value;
        wr_hit[rd_addr] <= 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clear_log();
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
  endtask
  task automatic setup(input int s);
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      par[i] = '0;
    end
    case (s)
      1: par[5] = 25'h1;
      2: par[63] = 25'h4;
      4: begin
        mem[10] = 25'h1FFFFFF;
        par[9] = 25'h1FFFFE3;
        par[10] = 25'h10;
      end
      default: ;
    endcase
  endtask
  task automatic run_pass(input bit poke);
    int lat = 0, bcnt = 0;
    clear_log();
    @(negedge clk) start = 1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      start = poke && ((busy && rd_addr == 6'd10) || done);
      if (done) begin
        lat = n;
        break;
      end
    end
    @(negedge clk) start = 0;
    chk("done_latency", lat, 66);
    chk("busy_cycles", bcnt, 65);
    repeat (2) @(negedge clk);
    chk("write_count", wr_cnt, 64);
    chk("done_pulses", done_cnt, 1);
    chk("idle_after_done", {busy, wr_en, done}, 0);
    chk("addr_after_done", rd_addr, 0);
  endtask
  initial begin
    int k;
    vt[0]  = '{0, 0,  25'h0};
    vt[1]  = '{0, 31, 25'h0};
    vt[2]  = '{0, 63, 25'h0};
    vt[3]  = '{1, 5,  {5{5'b00010}}};
    vt[4]  = '{1, 6,  {5{5'b10000}}};
    vt[5]  = '{1, 4,  25'h0};
    vt[6]  = '{1, 7,  25'h0};
    vt[7]  = '{2, 0,  {5{5'b00010}}};
    vt[8]  = '{2, 63, {5{5'b01000}}};
    vt[9]  = '{2, 1,  25'h0};
    vt[10] = '{4, 9,  {5{5'b00110}}};
    vt[11] = '{4, 10, {5{5'b01111}}};
    vt[12] = '{4, 11, {5{5'b01000}}};
    vt[13] = '{4, 12, 25'h0};
    setup(0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, wr_en, done}, 0);
    chk("reset_addr", rd_addr, 0);
    chk("reset_wval", write_value, 0);
    rst = 0;
    foreach (vt[i]) begin
      if (i == 0 || vt[i].scen != vt[i-1].scen) begin
        setup(vt[i].scen);
        run_pass(0);
      end
      chk($sformatf("scen%0d_z%0d", vt[i].scen, vt[i].z), wr[vt[i].z], vt[i].exp);
    end
    for (int i = 0; i < 64; i++) begin
      mem[i] = 25'($urandom);
      par[i] = {20'($urandom), 5'h1F};
    end
    run_pass(1);
    for (int i = 0; i < 64; i++) chk($sformatf("identity_z%0d", i), wr[i], mem[i]);
    setup(4);
    clear_log();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    k = 0;
    while (!(wr_en && rd_addr == 6'd20) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_z20", rd_addr, 20);
    rst = 1;
    #1;
    chk("rst_wr_en_async", wr_en, 0);
    chk("rst_busy_async", busy, 0);
    @(negedge clk) rst = 0;
    #1;
    chk("rst_addr", rd_addr, 0);
    chk("rst_idle", {busy, done}, 0);
    repeat (3) @(negedge clk);
    chk("rst_write_count", wr_cnt, 20);
    chk("rst_no_z20", wr_hit[20], 0);
    chk("rst_no_z63", wr_hit[63], 0);
    chk("rst_z10", wr[10], {5{5'b01111}});
    run_pass(0);
    chk("rerun_z10", wr[10], {5{5'b01111}});
    chk("rerun_z11", wr[11], {5{5'b01000}});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/col_parity_apply.md
Name: col_parity_apply

Overview:
- Consumer of the column-parity memory written by the column-parity stage.
- Reads each 25-bit state slice together with its column parity C[x][z], and the parity of the previous slice.
- Computes the theta-style mixed slice and writes it back through the same line-memory interface.
- Sits after the column-parity pass in the matrix-encoder pipeline and is sequenced by the top controller via a start/done handshake.

Parameters:
- N_SLICE, 64, number of 25-bit slices (memory lines) per matrix.
- ADDR_W, 6, address width; must satisfy 2**ADDR_W == N_SLICE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- mem_line  input  25  state slice at rd_addr; combinational (same-cycle) read. Bit index is 5*y+x.
- par_line  input  25  parity line at rd_addr; combinational read. Bits [4:0] = C[0..4]; bits [24:5] are ignored.
- rd_addr  output  ADDR_W  slice index for both memories; also the write address.
- wr_en  output  1  write strobe for write_value at rd_addr.
- write_value  output  25  mixed slice.
- busy  output  1  high in PRELOAD and RUN.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset values: state=IDLE, rd_addr=0, prev_par=5'b0, wr_en=0, done=0, busy=0. write_value is don't-care while wr_en=0 and is driven 0 for determinism.
- State IDLE:
  - rd_addr=0, wr_en=0.
  - start=1 -> PRELOAD, rd_addr<=N_SLICE-1.
- State PRELOAD (one cycle):
  - prev_par<=par_line[4:0], which is C[.][N_SLICE-1] and covers the z-1 wrap for slice 0.
  - wr_en=0; rd_addr<=0; -> RUN.
- State RUN (N_SLICE cycles, z = rd_addr):
  - D[x] = par_line[(x+4)%5] ^ prev_par[(x+1)%5].
  - write_value[5y+x] = mem_line[5y+x] ^ D[x], for y,x in 0..4.
  - wr_en=1, combinational from state.
  - prev_par<=par_line[4:0] each cycle.
  - z<N_SLICE-1: rd_addr<=z+1.
  - z==N_SLICE-1: rd_addr<=0, -> DONE.
- State DONE: done=1 for exactly one cycle, wr_en=0 -> IDLE.
- Latency: start sampled at edge t -> PRELOAD in cycle t+1, RUN in cycles t+2..t+1+N_SLICE, done high in cycle t+2+N_SLICE.
  - Total 66 cycles for the default N_SLICE.
- Pure XOR datapath, no carries. Index wrap is mod 5 in x and mod N_SLICE in z; the z wrap is handled only by PRELOAD.
- Boundary and corner cases:
  - start while busy or in DONE: ignored, no restart.
  - start in the same cycle done is high: ignored; the controller re-issues it.
  - rst asserted mid-pass: immediate return to IDLE, wr_en drops asynchronously, no further writes. Lines already written stay written; no rollback.
  - The memory must not change par_line between PRELOAD and RUN slice N_SLICE-1. The block does not check this.
- Memory read is combinational, so no wait states. Slice-z write and slice-z read happen in the same cycle. The write lands at the edge ending the cycle, so no read-after-write hazard exists.

Test Plan:
- All-zero memories, start pulse -> 64 writes, each write_value=25'h0. done high exactly 66 cycles after start; busy high 65 cycles.
- mem all-zero, par_line[4:0]=5'b00001 only at z=5 -> writes at z=5 have D=5'b00010 (x=1 set). Writes at z=6 have D=5'b10000 (x=4 set). All other slices are 0.
- Wrap check: parity 5'b00100 only at z=63 -> slice 0 gets D=5'b00010 (x=1, via prev_par). Slice 63 gets D=5'b01000 (x=3).
- Identity: parity all ones on every slice -> D=0 everywhere, write_value==mem_line for random mem contents.
- rst asserted during RUN at z=20 -> wr_en low immediately. rd_addr=0 and state IDLE after release. No write to z>=20. A fresh start runs the full 66-cycle pass.
- start pulsed at RUN z=10 and again coincident with done -> both ignored. Exactly 64 writes and one done pulse.
